// File: rtl/sharpen_ctrl.sv
// ---------------------------------------------------------------------------
// sharpen_ctrl
// Frame controller for a 3x3 sharpen pipeline. It feeds a raster-order pixel
// stream into an external 3-line buffer, tracks the source row/column, and
// presents the combinational sharpen result as an output stream covering only
// the interior pixels of the frame (borders produce no output).
//
// Ports
//   clk, rst            : single clock, asynchronous active-high reset
//   start               : one-cycle frame request, honoured only when idle
//   in_valid/in_ready   : input pixel handshake, in_pixel carries the data
//   lb_enable/lb_pixel  : line buffer shift strobe and its pixel input
//   lb_rstn             : line buffer synchronous active-low clear
//   core_pixel          : sharpen result of the buffer's current 3x3 window
//   out_valid/out_ready : output handshake, out_pixel carries the data
//   out_sof/eol/eof     : start-of-frame, end-of-line, end-of-frame flags
//   busy                : controller is not idle
//   frame_done          : one-cycle pulse when a frame has fully drained
// ---------------------------------------------------------------------------
module sharpen_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    output logic       lb_enable,
    output logic [7:0] lb_pixel,
    output logic       lb_rstn,
    input  logic [7:0] core_pixel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pixel,
    output logic       out_sof,
    output logic       out_eol,
    output logic       out_eof,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sof_q, out_sof_d;
    logic            out_eol_q, out_eol_d;
    logic            out_eof_q, out_eof_d;
    logic            frame_done_q, frame_done_d;

    logic            accept;
    logic            consumed;
    logic            last_pix;
    logic            interior;

    // Input is only taken while running and while no output is waiting, so
    // the buffer never shifts underneath a held, unconsumed output pixel.
    assign in_ready  = (state_q == RUN) & (~out_valid_q | out_ready);
    assign accept    = in_valid & in_ready;
    assign consumed  = out_valid_q & out_ready;
    assign last_pix  = (row_q == ROW_LAST) & (col_q == COL_LAST);
    assign interior  = (row_q >= ROW_TWO) & (col_q >= COL_TWO);

    assign lb_enable = accept;
    assign lb_pixel  = in_pixel;
    assign lb_rstn   = (state_q != CLEAR);

    // The window registered into the buffer is held stable while out_valid
    // is pending, so the core result can be forwarded without a register.
    assign out_pixel  = core_pixel;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign out_eof    = out_eof_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame sequencing. DRAIN waits for the final (end-of-frame) output to be
    // taken before returning to idle and raising frame_done.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if (accept && last_pix) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q || consumed) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Source position of the next pixel to be accepted.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (state_q == CLEAR) begin
            col_d = '0;
            row_d = '0;
        end else if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // An accepted interior pixel completes a window and raises out_valid one
    // cycle later. Accepting while an output is pending implies that output
    // is being consumed in the same cycle, so a border pixel simply clears it.
    always_comb begin
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        if (accept && interior) begin
            out_valid_d = 1'b1;
            out_sof_d   = (row_q == ROW_TWO) & (col_q == COL_TWO);
            out_eol_d   = (col_q == COL_LAST);
            out_eof_d   = last_pix;
        end else if (consumed) begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eol_d   = 1'b0;
            out_eof_d   = 1'b0;
        end
    end

endmodule

// File: tb/tb_sharpen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sharpen_ctrl
// Bench for sharpen_ctrl with an 8x4 frame. A behavioural 3-line buffer and
// sharpen core close the loop around the controller; expected outputs are
// computed directly from the frame image for every interior position.
// ---------------------------------------------------------------------------
module tb_sharpen_ctrl;

    localparam int W     = 8;
    localparam int H     = 4;
    localparam int NOUT  = (H - 2) * (W - 2);
    localparam int SRLEN = 2 * W + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_pixel = 8'd0;
    logic       in_ready;
    logic       lb_enable;
    logic [7:0] lb_pixel;
    logic       lb_rstn;
    logic [7:0] core_pixel;
    logic       out_valid;
    logic [7:0] out_pixel;
    logic       out_sof;
    logic       out_eol;
    logic       out_eof;
    logic       busy;
    logic       frame_done;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] img [H][W];
    logic [7:0] expPix [NOUT];
    logic       expSof [NOUT];
    logic       expEol [NOUT];
    logic       expEof [NOUT];

    int cyc = 0;
    int outIdx = 0;
    int eofCycle = -100;
    int doneCycle = -200;
    int doneCount = 0;
    int rstnLowCount = 0;
    int eolCount = 0;
    int sofCount = 0;

    logic [7:0] sr [SRLEN];

    sharpen_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_pixel(in_pixel),
        .lb_enable(lb_enable),
        .lb_pixel(lb_pixel),
        .lb_rstn(lb_rstn),
        .core_pixel(core_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pixel(out_pixel),
        .out_sof(out_sof),
        .out_eol(out_eol),
        .out_eof(out_eof),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference 3x3 sharpen: 5*centre minus the four edge neighbours, clamped.
    function automatic logic [7:0] sharpen(input logic [7:0] c, input logic [7:0] u,
                                           input logic [7:0] d, input logic [7:0] l,
                                           input logic [7:0] r);
        int v;
        v = 5 * int'(c) - int'(u) - int'(d) - int'(l) - int'(r);
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return 8'(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line buffer model: one long shift register, newest pixel at index 0, so
    // the pixel i rows up and j columns left of the newest sits at i*W+j.
    always @(posedge clk) begin
        if (!lb_rstn) begin
            for (int i = 0; i < SRLEN; i++) sr[i] <= 8'd0;
        end else if (lb_enable) begin
            for (int i = SRLEN - 1; i > 0; i--) sr[i] <= sr[i - 1];
            sr[0] <= lb_pixel;
        end
    end

    always_comb core_pixel = sharpen(sr[W + 1], sr[2 * W + 1], sr[1], sr[W + 2], sr[W]);

    task automatic loadImage(input int sel);
        int k;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                k = r * W + c;
                case (sel)
                    0:       img[r][c] = 8'(k * 8);
                    1:       img[r][c] = 8'(k * k * 5 + 3);
                    default: img[r][c] = ((r + c) % 2 == 1) ? 8'd200 : 8'd10;
                endcase
            end
        end
        for (int r = 2; r < H; r++) begin
            for (int c = 2; c < W; c++) begin
                k = (r - 2) * (W - 2) + (c - 2);
                expPix[k] = sharpen(img[r-1][c-1], img[r-2][c-1], img[r][c-1],
                                    img[r-1][c-2], img[r-1][c]);
                expSof[k] = (r == 2) && (c == 2);
                expEol[k] = (c == W - 1);
                expEof[k] = (r == H - 1) && (c == W - 1);
            end
        end
    endtask

    // Output scoreboard: every cycle with a valid output is compared against
    // the next expected interior pixel; a handshake advances the pointer.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("lb_enable_handshake", lb_enable, in_valid & in_ready);
            if (lb_enable) checkOutput("lb_pixel", lb_pixel, in_pixel);
            if (!lb_rstn) rstnLowCount++;
            if (frame_done) begin
                doneCount++;
                doneCycle = cyc;
            end
            if (out_valid && !out_ready) checkOutput("in_ready_while_held", in_ready, 0);
            if (out_valid) begin
                if (outIdx >= NOUT) begin
                    checkOutput("extra_output_index", outIdx, NOUT - 1);
                end else begin
                    checkOutput("out_pixel", out_pixel, expPix[outIdx]);
                    checkOutput("out_sof", out_sof, expSof[outIdx]);
                    checkOutput("out_eol", out_eol, expEol[outIdx]);
                    checkOutput("out_eof", out_eof, expEof[outIdx]);
                    if (out_ready) begin
                        if (out_eol) eolCount++;
                        if (out_sof) sofCount++;
                        if (out_eof) eofCycle = cyc;
                        outIdx++;
                    end
                end
            end
        end
    end

    // Drives one frame. stall holds out_ready low for 10 cycles after the
    // first output, pulseRun fires start mid-frame, abortAt>0 stops early.
    task automatic applyStimulus(input int sel, input bit stall, input bit pulseRun, input int abortAt);
        int  k;
        int  limit;
        int  budget;
        int  stallCnt;
        int  n;
        int  doneBefore;
        bit  pulsed;
        bit  hs;
        logic [7:0] held;
        loadImage(sel);
        outIdx = 0;
        eolCount = 0;
        sofCount = 0;
        eofCycle = -100;
        rstnLowCount = 0;
        doneBefore = doneCount;
        limit = (abortAt > 0) ? abortAt : W * H;
        held = 8'd0;

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("lb_rstn_in_clear", lb_rstn, 0);
        @(posedge clk); #1;
        checkOutput("lb_rstn_after_clear", lb_rstn, 1);

        k = 0;
        budget = 0;
        stallCnt = 0;
        pulsed = 1'b0;
        while (k < limit && budget < 400) begin
            budget++;
            in_valid = 1'b1;
            in_pixel = img[k / W][k % W];
            if (stall && out_valid && stallCnt < 10) begin
                out_ready = 1'b0;
                if (stallCnt == 0) held = out_pixel;
                stallCnt++;
            end else begin
                out_ready = 1'b1;
            end
            if (pulseRun && k == 5 && !pulsed) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            if (!out_ready) begin
                checkOutput("stall_in_ready", in_ready, 0);
                checkOutput("stall_lb_enable", lb_enable, 0);
                checkOutput("stall_out_pixel", out_pixel, held);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (hs) k++;
        end
        if (budget >= 400) checkOutput("input_accept_timeout", k, limit);
        if (stall) checkOutput("stall_cycles", stallCnt, 10);
        in_valid = 1'b0;
        out_ready = 1'b1;

        if (abortAt == 0) begin
            n = 0;
            while (doneCount == doneBefore && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("frame_done_seen", doneCount - doneBefore, 1);
            checkOutput("output_count", outIdx, NOUT);
            checkOutput("eol_count", eolCount, 2);
            checkOutput("sof_count", sofCount, 1);
            checkOutput("done_after_eof", doneCycle, eofCycle + 1);
            repeat (2) @(posedge clk);
            #1;
            checkOutput("frame_done_width", doneCount - doneBefore, 1);
            checkOutput("busy_after_frame", busy, 0);
            checkOutput("lb_rstn_low_cycles", rstnLowCount, 1);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_lb_enable"}, lb_enable, 0);
        checkOutput({tag, "_lb_rstn"}, lb_rstn, 1);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_out_flags"}, {out_sof, out_eol, out_eof}, 0);
        checkOutput({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Pin the reference model with hand-computed values.
        checkOutput("model_clamp_high", sharpen(8'd100, 8'd10, 8'd20, 8'd30, 8'd40), 255);
        checkOutput("model_mid", sharpen(8'd50, 8'd60, 8'd60, 8'd60, 8'd60), 10);
        checkOutput("model_clamp_low", sharpen(8'd10, 8'd100, 8'd100, 8'd100, 8'd100), 0);
        loadImage(0);
        checkOutput("model_frameA_first", expPix[0], 72);
        loadImage(1);
        checkOutput("model_frameB_first", expPix[0], 255);
        checkOutput("model_eol_pos", {expEol[5], expEol[11], expEol[4]}, 3'b110);

        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        in_valid = 1'b0;
        rst = 1'b0;

        // Input offered while idle must be refused.
        in_valid = 1'b1;
        in_pixel = 8'd99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("idle_in_ready", in_ready, 0);
            checkOutput("idle_lb_enable", lb_enable, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;

        $display("[TB] frame A: linear ramp, free-flowing output");
        applyStimulus(0, 1'b0, 1'b0, 0);
        $display("[TB] frame B: checkerboard, output stalled 10 cycles");
        applyStimulus(2, 1'b1, 1'b0, 0);
        $display("[TB] frame C: start pulsed during the frame");
        applyStimulus(1, 1'b0, 1'b1, 0);

        $display("[TB] frame D: reset after 20 pixels");
        applyStimulus(1, 1'b0, 1'b0, 20);
        in_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkResetOutputs("midreset");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] frame E: fresh frame after reset");
        applyStimulus(1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
